// File: rtl/diff_if.sv
// Host-side bus of the diff kernel: run control, b_mem load port, a_mem readback and result.
interface diff_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic [31:0]       n;
  logic              start;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] return_val;

  modport master (
    output n, start, ld_en, ld_addr, ld_data, rd_addr,
    input  rd_data, busy, done, return_val
  );

  modport slave (
    input  n, start, ld_en, ld_addr, ld_data, rd_addr,
    output rd_data, busy, done, return_val
  );
endinterface

// File: rtl/diff.sv
// Inverse prefix sum: rebuilds a[i]=b[i]-b[i-1] from b_mem into a_mem and returns a[n-1].
// HLS-style controller with one-hot block states, per-state step counter and branch_ready hand-off.
module diff (
  input  logic   sys_clk,
  input  logic   sys_rst_n,
  diff_if.slave  bus
);
  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 3;

  localparam logic [4:0] IDLE  = 5'b10000;
  localparam logic [4:0] INIT  = 5'b01000;
  localparam logic [4:0] START = 5'b00100;
  localparam logic [4:0] CALC  = 5'b00010;
  localparam logic [4:0] RET   = 5'b00001;

  logic [DATA_W-1:0] b_mem [0:MEM_DEPTH-1];
  logic [DATA_W-1:0] a_mem [0:MEM_DEPTH-1];

  logic [4:0]        cur_state,    state_nxt;
  logic [4:0]        last_state,   last_nxt;
  logic [CNT_W-1:0]  counter,      counter_nxt;
  logic              branch_ready, br_nxt;
  logic              busy_q,       busy_nxt;
  logic              done_q,       done_nxt;
  logic [DATA_W-1:0] ret_q,        ret_nxt;
  logic [DATA_W-1:0] n_lat,        n_lat_nxt;
  logic [DATA_W-1:0] reg_prev,     reg_prev_nxt;
  logic [DATA_W-1:0] reg_i,        reg_i_nxt;
  logic [DATA_W-1:0] reg_next,     reg_next_nxt;
  logic              reg_cmp,      reg_cmp_nxt;
  logic [DATA_W-1:0] reg_b,        reg_b_nxt;
  logic [DATA_W-1:0] reg_d,        reg_d_nxt;
  logic [ADDR_W-1:0] reg_addr,     reg_addr_nxt;
  logic              b_we;
  logic              a_we;

  // Next-state, step sequencing and datapath updates
  always_comb begin
    state_nxt    = cur_state;
    last_nxt     = last_state;
    counter_nxt  = counter;
    br_nxt       = branch_ready;
    done_nxt     = 1'b0;
    ret_nxt      = ret_q;
    n_lat_nxt    = n_lat;
    reg_prev_nxt = reg_prev;
    reg_i_nxt    = reg_i;
    reg_next_nxt = reg_next;
    reg_cmp_nxt  = reg_cmp;
    reg_b_nxt    = reg_b;
    reg_d_nxt    = reg_d;
    reg_addr_nxt = reg_addr;
    b_we         = 1'b0;
    a_we         = 1'b0;

    if (cur_state != IDLE) begin
      counter_nxt = counter + CNT_W'(1);
    end

    if (branch_ready) begin
      counter_nxt = '0;
      br_nxt      = 1'b0;
      last_nxt    = cur_state;
      case (cur_state)
        INIT:  state_nxt = START;
        START: state_nxt = reg_cmp ? RET : CALC;
        CALC:  state_nxt = START;
        RET: begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end else begin
      case (cur_state)
        IDLE: begin
          b_we = bus.ld_en;
          if (bus.start) begin
            n_lat_nxt = (bus.n > DATA_W'(MEM_DEPTH)) ? DATA_W'(MEM_DEPTH) : bus.n;
            state_nxt = INIT;
          end
        end
        INIT: begin
          if (counter == CNT_W'(0)) begin
            reg_prev_nxt = '0;
            br_nxt       = 1'b1;
          end
        end
        START: begin
          case (counter)
            CNT_W'(0): begin
              // Loop-index phi: fresh loop from INIT, advanced index from CALC
              if (last_state == CALC) reg_i_nxt = reg_next;
              else if (last_state == INIT) reg_i_nxt = '0;
            end
            CNT_W'(1): reg_cmp_nxt = (reg_i >= n_lat);
            CNT_W'(2): br_nxt = 1'b1;
            default: ;
          endcase
        end
        CALC: begin
          case (counter)
            CNT_W'(0): begin
              reg_b_nxt    = b_mem[reg_i[ADDR_W-1:0]];
              reg_next_nxt = reg_i + DATA_W'(1);
            end
            CNT_W'(2): reg_d_nxt = reg_b - reg_prev;
            CNT_W'(3): a_we = 1'b1;
            CNT_W'(4): begin
              reg_prev_nxt = reg_b;
              br_nxt       = 1'b1;
            end
            default: ;
          endcase
        end
        RET: begin
          case (counter)
            CNT_W'(0): reg_addr_nxt = ADDR_W'(n_lat - DATA_W'(1));
            CNT_W'(1): reg_b_nxt = a_mem[reg_addr];
            CNT_W'(3): begin
              ret_nxt = (n_lat == '0) ? '0 : reg_b;
              br_nxt  = 1'b1;
            end
            default: ;
          endcase
        end
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // State and working registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cur_state    <= IDLE;
      last_state   <= IDLE;
      counter      <= '0;
      branch_ready <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ret_q        <= '0;
      n_lat        <= '0;
      reg_prev     <= '0;
      reg_i        <= '0;
      reg_next     <= '0;
      reg_cmp      <= 1'b0;
      reg_b        <= '0;
      reg_d        <= '0;
      reg_addr     <= '0;
    end else begin
      cur_state    <= state_nxt;
      last_state   <= last_nxt;
      counter      <= counter_nxt;
      branch_ready <= br_nxt;
      busy_q       <= busy_nxt;
      done_q       <= done_nxt;
      ret_q        <= ret_nxt;
      n_lat        <= n_lat_nxt;
      reg_prev     <= reg_prev_nxt;
      reg_i        <= reg_i_nxt;
      reg_next     <= reg_next_nxt;
      reg_cmp      <= reg_cmp_nxt;
      reg_b        <= reg_b_nxt;
      reg_d        <= reg_d_nxt;
      reg_addr     <= reg_addr_nxt;
    end
  end

  // Memories keep their contents across reset
  always_ff @(posedge sys_clk) begin
    if (b_we) b_mem[bus.ld_addr] <= bus.ld_data;
    if (a_we) a_mem[reg_i[ADDR_W-1:0]] <= reg_d;
  end

  assign bus.rd_data    = a_mem[bus.rd_addr];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.return_val = ret_q;
endmodule

// File: tb/tb_diff.sv
// Randomized bench for diff against a behavioural array model of the inverse prefix sum.
module tb_diff;
  localparam int unsigned DEPTH = 256;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  diff_if bus ();
  diff dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] b_ref   [DEPTH];
  logic [31:0] a_ref   [DEPTH];
  bit          a_known [DEPTH];
  logic [31:0] a_orig  [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_b(input int addr, input logic [31:0] data);
    @(negedge sys_clk);
    bus.ld_en   = 1'b1;
    bus.ld_addr = 8'(addr);
    bus.ld_data = data;
    @(negedge sys_clk);
    bus.ld_en   = 1'b0;
    b_ref[addr] = data;
  endtask

  // Apply the reconstruction rule to the model arrays
  task automatic model_run(input int nl, input int upto);
    for (int i = 0; i < nl && i < upto; i++) begin
      a_ref[i]   = b_ref[i] - ((i == 0) ? 32'd0 : b_ref[i-1]);
      a_known[i] = 1'b1;
    end
  endtask

  task automatic check_amem(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (a_known[i]) begin
        bus.rd_addr = 8'(i);
        #1;
        check($sformatf("a_mem[%0d]", i), bus.rd_data, a_ref[i]);
      end
    end
  endtask

  task automatic run(input logic [31:0] nv, input bit noise, input bit restart);
    int nl, lat, c, extra;
    bit seen, busy_ok;
    logic [31:0] exp_ret;
    nl  = (nv > 32'(DEPTH)) ? DEPTH : int'(nv);
    lat = 12 + 10 * nl;
    model_run(nl, DEPTH);
    exp_ret = (nl == 0) ? 32'd0 : a_ref[nl-1];

    @(negedge sys_clk);
    bus.n     = nv;
    bus.start = 1'b1;
    @(posedge sys_clk);
    #1;
    bus.start = 1'b0;
    bus.n     = $urandom;
    check("busy_rise", 32'(bus.busy), 32'd1);

    c = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && c < lat + 20) begin
      @(posedge sys_clk);
      c++;
      #1;
      if (bus.done) seen = 1'b1;
      else if (!bus.busy) busy_ok = 1'b0;
      bus.ld_en = 1'b0;
      bus.start = 1'b0;
      if (!seen && noise && (c % 7 == 3)) begin
        bus.ld_en   = 1'b1;
        bus.ld_addr = 8'($urandom);
        bus.ld_data = $urandom;
      end
      if (!seen && restart && c == 20) bus.start = 1'b1;
    end
    bus.ld_en = 1'b0;
    bus.start = 1'b0;

    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(c + 1), 32'(lat));
    check("busy_thru", 32'(busy_ok), 32'd1);
    check("busy_fall", 32'(bus.busy), 32'd0);
    check("return_val", bus.return_val, exp_ret);
    @(posedge sys_clk);
    #1;
    check("done_pulse", 32'(bus.done), 32'd0);

    if (restart) begin
      extra = 0;
      repeat (60) begin
        @(posedge sys_clk);
        #1;
        if (bus.done || bus.busy) extra++;
      end
      check("no_restart", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] acc;
    int nv;
    bus.n = '0; bus.start = 1'b0; bus.ld_en = 1'b0;
    bus.ld_addr = '0; bus.ld_data = '0; bus.rd_addr = '0;
    for (int i = 0; i < int'(DEPTH); i++) a_known[i] = 1'b0;

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ret", bus.return_val, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Basic case
    load_b(0, 1); load_b(1, 3); load_b(2, 6); load_b(3, 10);
    run(32'd4, 1'b0, 1'b0);
    check_amem(0, 3);

    // Wrapping subtraction
    load_b(0, 5); load_b(1, 2);
    run(32'd2, 1'b0, 1'b0);
    check_amem(0, 3);

    // Empty run leaves a_mem untouched
    run(32'd0, 1'b0, 1'b0);
    check_amem(0, 3);

    load_b(0, 7);
    run(32'd1, 1'b0, 1'b0);
    check_amem(0, 0);

    // Clamped length with load attempts during the run
    for (int i = 0; i < int'(DEPTH); i++) load_b(i, 32'(i * (i + 1) / 2));
    run(32'd300, 1'b1, 1'b0);
    check_amem(0, DEPTH - 1);

    // Round trip through a prefix sum, with a start pulsed while busy
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      a_orig[i] = $urandom;
      acc = acc + a_orig[i];
      load_b(i, acc);
    end
    run(32'd16, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr = 8'(i);
      #1;
      check($sformatf("roundtrip[%0d]", i), bus.rd_data, a_orig[i]);
    end

    // Random runs
    for (int k = 0; k < 3; k++) begin
      nv = int'($urandom_range(0, 40));
      for (int i = 0; i < nv; i++) load_b(i, $urandom);
      run(32'(nv), 1'b0, 1'b0);
      check_amem(0, 40);
    end

    // Reset in CALC step 2 of iteration 3 with n=8
    for (int i = 0; i < 8; i++) load_b(i, $urandom);
    model_run(8, 3);
    @(negedge sys_clk);
    bus.n     = 32'd8;
    bus.start = 1'b1;
    @(posedge sys_clk);
    #1;
    bus.start = 1'b0;
    repeat (38) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_ret", bus.return_val, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    check_amem(0, 7);
    run(32'd8, 1'b0, 1'b0);
    check_amem(0, 7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
